// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice (two half adders + OR) processes one operand bit
// per clock, with valid/ready handshakes on the operand and result sides.

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic h1_s, h1_c, h2_s, h2_c, c_next;

    half_adder u_ha1 (
        .a_i     (a_sh_q[0]),
        .b_i     (b_sh_q[0]),
        .sum_o   (h1_s),
        .carry_o (h1_c)
    );

    half_adder u_ha2 (
        .a_i     (h1_s),
        .b_i     (carry_q),
        .sum_o   (h2_s),
        .carry_o (h2_c)
    );

    assign c_next = h1_c | h2_c;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // New sum bit enters at the MSB so the result ends up LSB-aligned.
                sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(h2_s) << (WIDTH - 1));
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = c_next;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    sum_d   = sum_sh_d;
                    cout_d  = c_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    // Held results live in sum_q/cout_q so they survive the next operation's RUN phase.
    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: cycle-level reference model plus result scoreboard for WIDTH=8,
// directed literal checks, and an exhaustive WIDTH=1 instance.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b1, cout;
    logic [7:0] a_in = '0, b_in = '0, sum;

    logic       in_valid1 = 1'b0, in_ready1, out_valid1, cout1;
    logic [0:0] a1 = '0, b1 = '0, sum1;
    logic       cin1 = 1'b0;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a_in(a1), .b_in(b1), .cin(cin1), .out_valid(out_valid1),
        .out_ready(1'b1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        else pass_cnt++;
    endtask

    // Reference model: an accepted operation is busy for WIDTH cycles, then its
    // result is presented until consumed; the result itself is plain addition.
    logic       m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0;
    int         m_age  = 0;
    logic [8:0] m_res  = '0;
    logic [7:0] m_sum  = '0;
    logic [8:0] sb_q[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_sum <= '0; m_cout <= 1'b0; m_age <= 0;
            sb_q.delete();
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_age  <= 0;
                m_res  <= {1'b0, a_in} + {1'b0, b_in} + {8'd0, cin};
                sb_q.push_back({1'b0, a_in} + {1'b0, b_in} + {8'd0, cin});
            end
        end else if (!m_done) begin
            m_age <= m_age + 1;
            if (m_age + 1 == 8) begin
                m_done <= 1'b1;
                m_sum  <= m_res[7:0];
                m_cout <= m_res[8];
            end
        end else if (out_ready) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("mdl_in_ready", {63'd0, in_ready}, {63'd0, rst_n && !m_busy});
        chk("mdl_out_valid", {63'd0, out_valid}, {63'd0, m_done});
        chk("mdl_sum", {56'd0, sum}, {56'd0, m_sum});
        chk("mdl_cout", {63'd0, cout}, {63'd0, m_cout});
        if (out_valid === 1'b1 && out_ready) begin
            if (sb_q.size() == 0) chk("sb_unexpected", 64'd1, 64'd0);
            else chk("sb_order", {55'd0, cout, sum}, {55'd0, sb_q.pop_front()});
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 40) chk("timeout_in_ready", 64'd0, 64'd1);
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec, input int stall);
        int n = 0;
        wait_ready();
        out_ready = (stall == 0);
        a_in = a; b_in = b; cin = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom);
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), 64'd8);
        chk("sum", {56'd0, sum}, {56'd0, es});
        chk("cout", {63'd0, cout}, {63'd0, ec});
        chk("in_ready_done", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; a_in = 8'($urandom); b_in = 8'($urandom);
            @(posedge clk); #1;
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_sum", {55'd0, cout, sum}, {55'd0, ec, es});
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_valid", {63'd0, out_valid}, 64'd0);
        chk("post_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_hold", {55'd0, cout, sum}, {55'd0, ec, es});
    endtask

    initial begin
        int acc[4];
        logic [8:0] r;
        logic [1:0] r1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {54'd0, in_ready, out_valid, cout, sum}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", {63'd0, in_ready}, 64'd1);

        op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
        op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 5);

        // Reset during the third RUN cycle.
        a_in = 8'hAA; b_in = 8'h55; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_ready_low", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        chk("midrst_out", {54'd0, in_ready, out_valid, cout, sum}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready_high", {63'd0, in_ready}, 64'd1);
        op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

        // Back-to-back: in_valid held high across four operand sets.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_in = 8'(8'h31 * (k + 1)); b_in = 8'(8'hC7 + k); cin = k[0];
            in_valid = 1'b1;
            wait_ready();
            acc[k] = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) chk("b2b_spacing", 64'(acc[k] - acc[k-1]), 64'd10);
        wait_ready();

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            logic c;
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            r = {1'b0, a} + {1'b0, b} + {8'd0, c};
            op(a, b, c, r[7:0], r[8], 0);
        end

        for (int i = 0; i < 8; i++) begin
            int n = 0;
            while (in_ready1 !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
            a1 = 1'(i); b1 = 1'(i >> 1); cin1 = 1'(i >> 2);
            r1 = 2'(a1) + 2'(b1) + 2'(cin1);
            in_valid1 = 1'b1;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            chk("w1_run_valid", {63'd0, out_valid1}, 64'd0);
            @(posedge clk); #1;
            chk("w1_done_valid", {63'd0, out_valid1}, 64'd1);
            chk("w1_result", {62'd0, cout1, sum1}, {62'd0, r1});
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
